// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types, frame constants and TX frame builder for the uart block.
// Exports: DATA_BITS, FRAME_BITS, tx_state_t, rx_state_t, tx_frame().
// Macro UART_PARITY_EN adds an even-parity bit between D7 and the stop bit.
package uart_pkg;
  localparam int DATA_BITS = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  // Whole frame as it leaves the pin, bit 0 first: start, data LSB first, [parity], stop.
  function automatic logic [FRAME_BITS-1:0] tx_frame(input logic [DATA_BITS-1:0] d);
`ifdef UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: receive FSM with mid-bit sampling, LSB-first shift register and one-cycle valid strobe.
// Ports: clk, rst (sync active-high), rx_in (serial, idle 1), data (last good byte), valid (update pulse).
// Macro UART_PARITY_EN: expects an even-parity bit; a mismatch suppresses valid without entering BREAK.
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] sh;
`ifdef UART_PARITY_EN
  logic perr;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      data  <= '0;
      valid <= 1'b0;
`ifdef UART_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        RX_IDLE: if (!rx_in) begin
          state <= RX_START;
          cnt   <= '0;
        end
        // A start bit that has gone high again by mid-bit is treated as a glitch.
        RX_START: if (cnt == HALF) begin
          cnt   <= '0;
          idx   <= '0;
          state <= rx_in ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == LAST) begin
          cnt <= '0;
          sh  <= {rx_in, sh[DATA_BITS-1:1]};
          idx <= idx + 1'b1;
`ifdef UART_PARITY_EN
          if (idx == 3'(DATA_BITS - 1)) state <= RX_PARITY;
`else
          if (idx == 3'(DATA_BITS - 1)) state <= RX_STOP;
`endif
        end else cnt <= cnt + 1'b1;
`ifdef UART_PARITY_EN
        RX_PARITY: if (cnt == LAST) begin
          cnt   <= '0;
          perr  <= rx_in ^ (^sh);
          state <= RX_STOP;
        end else cnt <= cnt + 1'b1;
`endif
        RX_STOP: if (cnt == LAST) begin
          cnt   <= '0;
          state <= rx_in ? RX_IDLE : RX_BREAK;
`ifdef UART_PARITY_EN
          if (rx_in && !perr) begin
`else
          if (rx_in) begin
`endif
            data  <= sh;
            valid <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        RX_BREAK: if (rx_in) state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart.sv
// uart: full-duplex 8N1 UART, inline transmitter plus uart_rx receiver on one clock.
// Ports: clk, tx_rx_enable (sync active-high reset), tx_rx_start (level TX request), tx_data,
//        tx_out (idle 1), rx_in (idle 1), rx_received_data, valid (one-cycle), busy (TX frame active).
// Macro UART_PARITY_EN: inserts/checks an even-parity bit, making frames 11 bits long.
module uart import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic                 clk,
  input  logic                 tx_rx_enable,
  input  logic                 tx_rx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_received_data,
  output logic                 valid,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] FINAL = 4'(FRAME_BITS - 1);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  logic [FRAME_BITS-1:0] sh;
  // The whole frame is latched at acceptance and shifted out; idx is the bit now on the pin.
  always_ff @(posedge clk) begin
    if (tx_rx_enable) begin
      state  <= TX_IDLE;
      tx_out <= 1'b1;
      busy   <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '1;
    end else if (state == TX_IDLE) begin
      if (tx_rx_start) begin
        sh     <= tx_frame(tx_data);
        tx_out <= 1'b0;
        busy   <= 1'b1;
        cnt    <= '0;
        idx    <= '0;
        state  <= TX_START;
      end
    end else if (cnt == LAST) begin
      cnt <= '0;
      if (idx == FINAL) begin
        state  <= TX_IDLE;
        tx_out <= 1'b1;
        busy   <= 1'b0;
      end else begin
        idx    <= idx + 1'b1;
        sh     <= sh >> 1;
        tx_out <= sh[1];
        state  <= (idx + 1'b1 <= 4'(DATA_BITS)) ? TX_DATA :
                  (idx + 1'b1 == FINAL) ? TX_STOP : TX_PARITY;
      end
    end else cnt <= cnt + 1'b1;
  end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst   (tx_rx_enable),
    .rx_in (rx_in),
    .data  (rx_received_data),
    .valid (valid)
  );
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed and randomized checks of uart TX/RX against a frame-level reference model.
module tb_uart;
  localparam int C = 2;
  logic clk = 1'b0;
  logic tx_rx_enable = 1'b1;
  logic tx_rx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_out;
  logic rx_in = 1'b1;
  logic [7:0] rx_received_data;
  logic valid;
  logic busy;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int vcount = 0;
  int vcyc = 0;
  int base = 0;
  int t0 = 0;

  always #5 clk = ~clk;

  uart #(.CLKS_PER_BIT(C)) dut (
    .clk              (clk),
    .tx_rx_enable     (tx_rx_enable),
    .tx_rx_start      (tx_rx_start),
    .tx_data          (tx_data),
    .tx_out           (tx_out),
    .rx_in            (rx_in),
    .rx_received_data (rx_received_data),
    .valid            (valid),
    .busy             (busy)
  );

  always @(posedge clk) cyc++;
  always @(negedge clk) if (valid === 1'b1) begin
    vcount++;
    vcyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit i of an 8N1 frame carrying d: start 0, data LSB first, stop 1.
  function automatic logic fbit(input logic [7:0] d, input int i);
    return (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : 1'b1;
  endfunction

  // Called at a negedge with TX idle. With hold, a second frame (carrying d2) must follow after one idle cycle.
  task automatic tx_frames(input logic [7:0] d1, input logic [7:0] d2, input bit hold);
    logic [7:0] d;
    tx_data = d1;
    tx_rx_start = 1'b1;
    @(negedge clk);
    for (int f = 0; f < (hold ? 2 : 1); f++) begin
      d = (f == 0) ? d1 : d2;
      for (int i = 0; i < 10 * C; i++) begin
        if (f == 0 && i == 0) begin
          tx_data = hold ? d2 : 8'($urandom);
          if (!hold) tx_rx_start = 1'b0;
        end
        if (f == 1 && i == 0) tx_rx_start = 1'b0;
        chk("tx_out", tx_out, fbit(d, i / C));
        chk("tx_busy", busy, 1);
        @(negedge clk);
      end
      if (f == 0 && hold) begin
        chk("tx_gap_out", tx_out, 1);
        chk("tx_gap_busy", busy, 0);
        @(negedge clk);
      end
    end
    chk("tx_idle_out", tx_out, 1);
    chk("tx_idle_busy", busy, 0);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_in = (i == 9) ? stop : fbit(d, i);
      repeat (C) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] d);
    base = vcount;
    rx_send(d, 1'b1);
    repeat (2) @(negedge clk);
    chk("rx_valid_count", vcount - base, 1);
    chk("rx_data", rx_received_data, d);
    chk("rx_latency", vcyc - t0, 19 * C / 2 + 1);
  endtask

  initial begin
    tx_rx_start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", rx_received_data, 8'h00);
    tx_rx_enable = 1'b0;
    tx_rx_start = 1'b0;
    @(negedge clk);
    tx_frames(8'h45, 8'h45, 1'b0);
    tx_frames(8'h45, 8'h45, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) tx_frames(8'($urandom), 8'($urandom), i == 1);
    rx_frame(8'h55);
    base = vcount;
    rx_in = 1'b0;
    repeat (11 * C) @(negedge clk);
    chk("ferr_no_valid", vcount - base, 0);
    chk("ferr_hold", rx_received_data, 8'h55);
    rx_in = 1'b1;
    repeat (C) @(negedge clk);
    rx_frame(8'hA3);
    base = vcount;
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (12 * C) @(negedge clk);
    chk("glitch_no_valid", vcount - base, 0);
    chk("glitch_hold", rx_received_data, 8'hA3);
    for (int i = 0; i < 4; i++) rx_frame(8'($urandom));
    rx_frame(8'h3C);
    tx_data = 8'($urandom);
    tx_rx_start = 1'b1;
    rx_in = 1'b0;
    @(negedge clk);
    tx_rx_start = 1'b0;
    repeat (7) @(negedge clk);
    tx_rx_enable = 1'b1;
    @(negedge clk);
    chk("abort_tx_out", tx_out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_data", rx_received_data, 8'h00);
    tx_rx_enable = 1'b0;
    rx_in = 1'b1;
    base = vcount;
    repeat (12 * C) @(negedge clk);
    chk("abort_no_valid", vcount - base, 0);
    chk("abort_idle_busy", busy, 0);
    rx_frame(8'($urandom));
    tx_frames(8'($urandom), 8'($urandom), 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
